shared_adder_arbiter: RTL

Shares one 32-bit `carry_skip_adder` among NUM_REQ requesters using round-robin arbitration and valid/ready handshakes on both sides. It sits between the client blocks that issue add operations and the single adder instance. The winning operands are added combinationally and the 33-bit sum is captured in a one-entry output register, tagged with the requester index. The output register gives single-cycle latency and full throughput under back-pressure-free operation.

---
 rtl/adder_arb_pkg.sv | 6 +
 rtl/carry_skip_adder.sv | 29 ++
 rtl/rr_pick.sv | 29 ++
 rtl/shared_adder_arbiter.sv | 65 ++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: widths and output-slot state shared by the arbiter and its adder.
package adder_arb_pkg;
  localparam int OPERAND_W = 32;
  localparam int RESULT_W = 33;
  typedef enum logic {EMPTY, FULL} slot_state_t;
endpackage

// File: rtl/carry_skip_adder.sv
// carry_skip_adder: 32-bit adder, 4-bit ripple blocks whose carry bypasses fully-propagating blocks.
module carry_skip_adder
  import adder_arb_pkg::*;
(
  input  logic [OPERAND_W-1:0] i_a,
  input  logic [OPERAND_W-1:0] i_b,
  input  logic                 i_cin,
  output logic [OPERAND_W-1:0] o_sum,
  output logic                 o_cout
);
  logic [OPERAND_W-1:0] w_p, w_g;
  logic w_c, w_cb;
  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;
  always_comb begin
    o_sum = '0;
    w_c = i_cin;
    w_cb = i_cin;
    for (int b = 0; b < OPERAND_W / 4; b++) begin
      w_cb = w_c;
      for (int k = 0; k < 4; k++) begin
        o_sum[4*b+k] = w_p[4*b+k] ^ w_c;
        w_c = w_g[4*b+k] | (w_p[4*b+k] & w_c);
      end
      w_c = (&w_p[4*b +: 4]) ? w_cb : w_c;
    end
    o_cout = w_c;
  end
endmodule

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; first valid index at or after ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_found
);
  int j;
  always_comb begin
    o_grant = '0;
    o_idx = '0;
    o_found = 1'b0;
    j = 0;
    // Scan farthest offset first so the nearest valid requester wins last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(i_ptr) + k) % NUM_REQ;
      if (i_valid[j]) begin
        o_grant = '0;
        o_grant[j] = 1'b1;
        o_idx = ID_W'(j);
        o_found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/shared_adder_arbiter.sv
// shared_adder_arbiter: round-robin sharing of one carry-skip adder with a registered, tagged result.
module shared_adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  output logic [NUM_REQ-1:0]             o_req_ready,
  input  logic [NUM_REQ*OPERAND_W-1:0]   i_req_add1,
  input  logic [NUM_REQ*OPERAND_W-1:0]   i_req_add2,
  output logic                           o_rsp_valid,
  input  logic                           i_rsp_ready,
  output logic [RESULT_W-1:0]            o_rsp_result,
  output logic [ID_W-1:0]                o_rsp_id
);
  slot_state_t r_state, w_state_nxt;
  logic [ID_W-1:0] r_ptr, r_id, w_idx;
  logic [NUM_REQ-1:0] w_grant;
  logic w_found, w_free, w_accept, w_cout;
  logic [OPERAND_W-1:0] w_a, w_b, w_sum;
  logic [RESULT_W-1:0] r_result;
  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_valid(i_req_valid),
    .i_ptr(r_ptr),
    .o_grant(w_grant),
    .o_idx(w_idx),
    .o_found(w_found)
  );
  assign w_a = i_req_add1[w_idx*OPERAND_W +: OPERAND_W];
  assign w_b = i_req_add2[w_idx*OPERAND_W +: OPERAND_W];
  carry_skip_adder u_add (
    .i_a(w_a),
    .i_b(w_b),
    .i_cin(1'b0),
    .o_sum(w_sum),
    .o_cout(w_cout)
  );
  // The slot can refill in the same cycle it drains.
  assign w_free = (r_state == EMPTY) || i_rsp_ready;
  assign w_accept = w_found && w_free && !i_rst;
  assign o_req_ready = w_accept ? w_grant : '0;
  assign o_rsp_valid = r_state == FULL;
  assign o_rsp_result = r_result;
  assign o_rsp_id = r_id;
  always_comb begin
    w_state_nxt = w_accept ? FULL : (i_rsp_ready ? EMPTY : r_state);
  end
  always_ff @(posedge i_clk) begin
    r_state <= i_rst ? EMPTY : w_state_nxt;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
      r_id <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_ptr <= (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
      r_id <= w_idx;
      r_result <= {w_cout, w_sum};
    end
  end
endmodule
